// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the adder round-robin scheduler.
package adder_sched_pkg;

  // Width of the adder datapath and of every operand and result.
  localparam int DATA_W = 8;

  // Largest requester count the scheduler supports, and the id width it needs.
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  // Bits needed to name one of n requesters. Never less than one bit.
  function automatic int idWidth(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  // Tag that travels alongside an operation while the adder computes it.
  // The id field is sized for the largest supported requester count.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter. The pointer holds the most recent winner, and
// the search for the next winner starts one position after it. The pointer
// moves only when the caller signals that the current grant was taken.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N-1:0]           req_i,
  input  logic                   advance_i,
  output logic [N-1:0]           grant_o,
  output logic [idWidth(N)-1:0]  grantIdx_o
);

  localparam int IDX_W = idWidth(N);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] pickIdx;
  logic [IDX_W:0]   cand;
  logic             found;

  // Scan cyclically from ptr+1 and keep the first requester that is asking.
  always_comb begin
    grant_o = '0;
    pickIdx = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        pickIdx = cand[IDX_W-1:0];
      end
    end
    if (found) begin
      grant_o[pickIdx] = 1'b1;
    end
  end

  assign grantIdx_o = pickIdx;

  // The pointer only advances when a grant is actually consumed.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = pickIdx;
    end
  end

  // After reset the pointer sits on the last requester, so requester 0 is
  // first in line.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one fixed-latency 8-bit adder among N_REQ requesters. Each cycle at
// most one operand pair is granted round-robin and driven to the adder. A tag
// travels through a pipeline that matches the adder latency, so every sum
// comes back labelled with the requester that sent it.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADD_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pause_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [DATA_W*N_REQ-1:0]    req_a_i,
  input  logic [DATA_W*N_REQ-1:0]    req_b_i,
  output logic [DATA_W-1:0]          add_a_o,
  output logic [DATA_W-1:0]          add_b_o,
  input  logic [DATA_W-1:0]          add_x_i,
  output logic                       rsp_valid_o,
  output logic [idWidth(N_REQ)-1:0]  rsp_id_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       idle_o,
  output logic [CNT_W-1:0]           issue_cnt_o,
  output logic [CNT_W-1:0]           retire_cnt_o
);

  localparam int ID_W  = idWidth(N_REQ);
  // One stage covers the operand register, the rest cover the adder itself.
  localparam int DEPTH = 1 + ADD_LATENCY;

  logic [N_REQ-1:0]  candidates;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grantIdx;
  logic              transfer;
  logic [DATA_W-1:0] selA;
  logic [DATA_W-1:0] selB;

  logic [DATA_W-1:0] addA_q, addA_d;
  logic [DATA_W-1:0] addB_q, addB_d;
  tag_t              tagPipe_q [DEPTH];
  tag_t              tagPipe_d [DEPTH];
  tag_t              tagEnd;
  logic              pipeBusy;
  logic              rspValid_q, rspValid_d;
  logic [ID_W-1:0]   rspId_q, rspId_d;
  logic [DATA_W-1:0] rspData_q, rspData_d;
  logic [CNT_W-1:0]  issueCnt_q, issueCnt_d;
  logic [CNT_W-1:0]  retireCnt_q, retireCnt_d;

  // While paused nobody competes, but operations already in flight finish.
  assign candidates = pause_i ? '0 : req_valid_i;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (candidates),
    .advance_i  (transfer),
    .grant_o    (grant),
    .grantIdx_o (grantIdx)
  );

  assign req_ready_o = grant;
  assign transfer    = |(req_valid_i & grant);

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        selA = selA | req_a_i[i*DATA_W +: DATA_W];
        selB = selB | req_b_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Operands go to the adder one cycle after the handshake. When there is no
  // transfer they return to zero.
  always_comb begin
    addA_d = '0;
    addB_d = '0;
    if (transfer) begin
      addA_d = selA;
      addB_d = selB;
    end
  end

  // Shift the tag pipeline. A bubble tag enters whenever nothing was granted.
  always_comb begin
    tagPipe_d[0].valid = transfer;
    tagPipe_d[0].id    = transfer ? MAX_ID_W'(grantIdx) : '0;
    for (int k = 1; k < DEPTH; k++) begin
      tagPipe_d[k] = tagPipe_q[k-1];
    end
  end

  assign tagEnd = tagPipe_q[DEPTH-1];

  // A valid tag at the pipeline end means add_x_i holds its sum right now.
  always_comb begin
    rspValid_d = tagEnd.valid;
    rspId_d    = rspId_q;
    rspData_d  = rspData_q;
    if (tagEnd.valid) begin
      rspId_d   = ID_W'(tagEnd.id);
      rspData_d = add_x_i;
    end
  end

  // Free-running wrap-around counters for accepted and delivered operations.
  always_comb begin
    issueCnt_d  = issueCnt_q  + {{(CNT_W-1){1'b0}}, transfer};
    retireCnt_d = retireCnt_q + {{(CNT_W-1){1'b0}}, tagEnd.valid};
  end

  // Any valid tag still travelling keeps the block busy.
  always_comb begin
    pipeBusy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pipeBusy = pipeBusy | tagPipe_q[k].valid;
    end
  end

  assign idle_o = ~transfer & ~pipeBusy & ~rspValid_q;

  // All scheduler state. Reset drops in-flight work so no stale result can
  // surface after release.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addA_q      <= '0;
      addB_q      <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= '0;
      rspData_q   <= '0;
      issueCnt_q  <= '0;
      retireCnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tagPipe_q[k] <= '0;
      end
    end else begin
      addA_q      <= addA_d;
      addB_q      <= addB_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspData_q   <= rspData_d;
      issueCnt_q  <= issueCnt_d;
      retireCnt_q <= retireCnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        tagPipe_q[k] <= tagPipe_d[k];
      end
    end
  end

  assign add_a_o      = addA_q;
  assign add_b_o      = addB_q;
  assign rsp_valid_o  = rspValid_q;
  assign rsp_id_o     = rspId_q;
  assign rsp_data_o   = rspData_q;
  assign issue_cnt_o  = issueCnt_q;
  assign retire_cnt_o = retireCnt_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed and random stimulus for adder_rr_sched. The bench models the
// adder, keeps a reference scoreboard of expected responses, and checks the
// outputs every cycle.
module tb_adder_rr_sched;

  localparam int N   = 4;
  localparam int L   = 1;
  localparam int CW  = 8;
  localparam int MAXDIFF = L + 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              pause_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [8*N-1:0]    req_a_i;
  logic [8*N-1:0]    req_b_i;
  logic [7:0]        add_a_o;
  logic [7:0]        add_b_o;
  logic [7:0]        add_x_i;
  logic              rsp_valid_o;
  logic [1:0]        rsp_id_o;
  logic [7:0]        rsp_data_o;
  logic              idle_o;
  logic [CW-1:0]     issue_cnt_o;
  logic [CW-1:0]     retire_cnt_o;

  adder_rr_sched #(
    .N_REQ       (N),
    .ADD_LATENCY (L),
    .CNT_W       (CW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .pause_i      (pause_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .add_a_o      (add_a_o),
    .add_b_o      (add_b_o),
    .add_x_i      (add_x_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .idle_o       (idle_o),
    .issue_cnt_o  (issue_cnt_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  // Adder stand-in: the sum of the presented operands appears L cycles later.
  logic [7:0] adderPipe [L];
  always @(posedge clk) begin
    adderPipe[0] <= add_a_o + add_b_o;
    for (int k = 1; k < L; k++) begin
      adderPipe[k] <= adderPipe[k-1];
    end
  end
  assign add_x_i = adderPipe[L-1];

  // Reference model state.
  typedef struct {
    int cyc;
    int id;
    int data;
  } rsp_t;

  rsp_t       expQ[$];
  int         mPtr;
  int         mIssue;
  int         mRetire;
  int         cycleNum;
  int         lastId;
  int         lastData;
  logic [7:0] expA;
  logic [7:0] expB;
  int         total = 0;
  int         bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycleNum);
    end
  endtask

  // Round-robin choice: the first asking requester after the last winner.
  function automatic int modelGrant(input logic [N-1:0] v, input logic p, input int ptr);
    if (p) return -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [8*N-1:0] packOps(input int o0, input int o1, input int o2, input int o3);
    return {o3[7:0], o2[7:0], o1[7:0], o0[7:0]};
  endfunction

  task automatic modelReset();
    expQ.delete();
    mPtr     = N - 1;
    mIssue   = 0;
    mRetire  = 0;
    lastId   = 0;
    lastData = 0;
    expA     = 8'd0;
    expB     = 8'd0;
  endtask

  // One clock cycle: drive inputs, check everything at the falling edge,
  // advance the model, then step past the next rising edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [8*N-1:0] a,
                               input logic [8*N-1:0] b, input logic p);
    int   g;
    int   sa;
    int   sb;
    bit   busy;
    rsp_t r;
    logic [N-1:0] expReady;
    req_valid_i = v;
    req_a_i     = a;
    req_b_i     = b;
    pause_i     = p;
    @(negedge clk);
    g        = modelGrant(v, p, mPtr);
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("ready", 32'(req_ready_o), 32'(expReady));
    checkOutput("add_a", 32'(add_a_o), 32'(expA));
    checkOutput("add_b", 32'(add_b_o), 32'(expB));
    busy = (expQ.size() > 0);
    checkOutput("idle", 32'(idle_o), 32'((g < 0) && !busy));
    if (expQ.size() > 0 && expQ[0].cyc == cycleNum) begin
      r = expQ.pop_front();
      mRetire++;
      lastId   = r.id;
      lastData = r.data;
      checkOutput("rsp_valid", 32'(rsp_valid_o), 32'd1);
    end else begin
      checkOutput("rsp_valid", 32'(rsp_valid_o), 32'd0);
    end
    checkOutput("rsp_id", 32'(rsp_id_o), 32'(lastId));
    checkOutput("rsp_data", 32'(rsp_data_o), 32'(lastData));
    checkOutput("issue_cnt", 32'(issue_cnt_o), 32'(mIssue % (1 << CW)));
    checkOutput("retire_cnt", 32'(retire_cnt_o), 32'(mRetire % (1 << CW)));
    checkOutput("outstanding", 32'(((CW)'(issue_cnt_o - retire_cnt_o)) <= CW'(MAXDIFF)), 32'd1);
    if (g >= 0) begin
      sa = int'(a[8*g +: 8]);
      sb = int'(b[8*g +: 8]);
      r.cyc  = cycleNum + L + 2;
      r.id   = g;
      r.data = (sa + sb) % 256;
      expQ.push_back(r);
      mPtr   = g;
      mIssue++;
      expA   = sa[7:0];
      expB   = sb[7:0];
    end else begin
      expA = 8'd0;
      expB = 8'd0;
    end
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus('0, '0, '0, 1'b0);
    end
  endtask

  // Reset pulse across one rising edge, with the async clear checked at once.
  task automatic pulseReset();
    req_valid_i = '0;
    pause_i     = 1'b0;
    reset_i     = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_issue", 32'(issue_cnt_o), 32'd0);
    checkOutput("rst_retire", 32'(retire_cnt_o), 32'd0);
    checkOutput("rst_add_a", 32'(add_a_o), 32'd0);
    checkOutput("rst_add_b", 32'(add_b_o), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id_o), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst_idle", 32'(idle_o), 32'd1);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    modelReset();
    cycleNum++;
  endtask

  initial begin
    reset_i     = 1'b1;
    pause_i     = 1'b0;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    cycleNum    = 0;
    modelReset();
    #3;
    pulseReset();

    // Single operation from requester 0: 3 + 5.
    applyStimulus(4'b0001, packOps(3, 0, 0, 0), packOps(5, 0, 0, 0), 1'b0);
    idleCycles(4);

    // Carries are discarded.
    applyStimulus(4'b0100, packOps(0, 0, 200, 0), packOps(0, 0, 100, 0), 1'b0);
    applyStimulus(4'b0010, packOps(0, 255, 0, 0), packOps(0, 1, 0, 0), 1'b0);
    idleCycles(4);

    // All four requesters continuously valid: strict rotation.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, packOps(0, 1, 2, 3), packOps(10, 10, 10, 10), 1'b0);
    end
    idleCycles(4);

    // Fresh pointer, requesters 1 and 3, then requester 0 joins.
    pulseReset();
    applyStimulus(4'b1010, packOps(0, 7, 0, 9), packOps(0, 1, 0, 2), 1'b0);
    applyStimulus(4'b1010, packOps(0, 7, 0, 9), packOps(0, 1, 0, 2), 1'b0);
    applyStimulus(4'b1011, packOps(4, 7, 0, 9), packOps(4, 1, 0, 2), 1'b0);
    applyStimulus(4'b1010, packOps(4, 7, 0, 9), packOps(4, 1, 0, 2), 1'b0);
    idleCycles(4);

    // Pause during full load, then resume from the saved pointer.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, packOps(11, 22, 33, 44), packOps(1, 2, 3, 4), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, packOps(11, 22, 33, 44), packOps(1, 2, 3, 4), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, packOps(11, 22, 33, 44), packOps(1, 2, 3, 4), 1'b0);
    end
    idleCycles(4);

    // Reset with two operations in flight: their results must vanish.
    applyStimulus(4'b1111, packOps(50, 60, 70, 80), packOps(5, 6, 7, 8), 1'b0);
    applyStimulus(4'b1111, packOps(50, 60, 70, 80), packOps(5, 6, 7, 8), 1'b0);
    pulseReset();
    idleCycles(5);
    applyStimulus(4'b1111, packOps(1, 2, 3, 4), packOps(1, 1, 1, 1), 1'b0);
    idleCycles(4);

    // Random traffic with occasional pauses.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom,
                    1'($urandom_range(0, 7) == 0));
    end
    idleCycles(4);

    // One requester held valid long enough for both counters to wrap.
    for (int i = 0; i < 270; i++) begin
      applyStimulus(4'b0100, $urandom, $urandom, 1'b0);
    end
    idleCycles(5);
    checkOutput("drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Shares the single 8-bit adder datapath (MyTopLevel: io_A, io_B -> io_X) between N_REQ requesters.
- Round-robin arbitration; one operand pair issued per cycle.
- Tracks in-flight operations through the adder's fixed latency.
- Returns each sum tagged with the originating requester ID.
- Sits between the stimulus/BFM layer and the adder instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADD_LATENCY, 1, cycles from add_a_o/add_b_o change to the corresponding add_x_i (fixed property of the adder, >=1)
CNT_W, 16, width of issue/retire counters

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  asynchronous, active-high reset
pause_i  input  1  when high, no new grants; in-flight ops complete
req_valid_i  input  N_REQ  per-requester operand-pair valid
req_ready_o  output  N_REQ  per-requester grant/accept
req_a_i  input  8*N_REQ  operand A, requester i at bits [8i+7:8i]
req_b_i  input  8*N_REQ  operand B, same packing
add_a_o  output  8  to adder io_A
add_b_o  output  8  to adder io_B
add_x_i  input  8  from adder io_X
rsp_valid_o  output  1  one-cycle result pulse, no backpressure
rsp_id_o  output  clog2(N_REQ)  requester index of result
rsp_data_o  output  8  sum
idle_o  output  1  no grant this cycle and nothing in flight
issue_cnt_o  output  CNT_W  accepted operations, wraps
retire_cnt_o  output  CNT_W  delivered results, wraps

Behaviour:
- Reset (async assert, sync release) drives these outputs/state to 0:
  - req_ready_o, add_a_o, add_b_o, rsp_valid_o, rsp_id_o, rsp_data_o, issue_cnt_o, retire_cnt_o.
  - In-flight pipeline valid bits.
  - RR pointer, reset to N_REQ-1 so requester 0 has first priority.
  - idle_o=1 after reset.
- Arbitration (combinational):
  - Candidates = req_valid_i when pause_i=0, else none.
  - Grant = first candidate scanning cyclically from ptr+1.
  - req_ready_o is one-hot or zero.
  - req_ready_o may depend on req_valid_i; requesters must not make valid depend on ready.
  - Transfer = req_valid_i[i] & req_ready_o[i].
- On a transfer at cycle t:
  - ptr <= i.
  - add_a_o/add_b_o <= requester i operands (visible t+1).
  - Tag {valid=1, id=i} enters a shift pipeline of depth 1+ADD_LATENCY.
  - issue_cnt_o increments.
- No transfer: add_a_o/add_b_o <= 0; a tag with valid=0 enters the pipeline.
- ptr changes only on a transfer.
- Result timing:
  - When the tag reaches the pipeline end (add_x_i now holds that sum), register rsp_data_o <= add_x_i, rsp_id_o <= id, rsp_valid_o <= 1.
  - Handshake-to-rsp_valid_o latency = ADD_LATENCY+2 cycles (3 at default).
  - rsp_id_o/rsp_data_o hold their last value when rsp_valid_o=0.
  - retire_cnt_o increments with each rsp_valid_o.
- Throughput: one op per cycle sustained; results emerge in issue order, back-to-back.
- Arithmetic: 8-bit modulo 256, carry discarded (adder behaviour); this block does no arithmetic on data.
- idle_o = no transfer this cycle AND no valid tag in pipeline AND rsp_valid_o=0.
- Boundaries:
  - pause_i rising mid-burst: grant stops the same cycle; already-issued ops still deliver.
  - All requesters valid: strict rotation 0,1,2,3,0…
  - Single requester continuously valid: granted every cycle.
  - Counters wrap 2^CNT_W-1 -> 0.
  - reset_i mid-operation: all in-flight results discarded, no rsp_valid_o pulse after release until new ops complete ADD_LATENCY+2 later.
  - issue_cnt_o - retire_cnt_o (mod 2^CNT_W) <= ADD_LATENCY+2 at all times.

Decomposition:
- Package adder_sched_pkg:
  - Constant DATA_W=8.
  - Function for ID width (clog2 of N_REQ).
  - Tag typedef {valid, id}.
- Sub-module rr_arbiter: N-way round-robin with ptr register, inputs req/advance, output one-hot grant. Reusable by other shared-resource controllers.
- Pipeline, operand mux, counters stay in the top.

Test Plan:
- Reset then req0 valid with A=3, B=5 at cycle t -> req_ready_o=0001 at t; add_a_o=3, add_b_o=5 at t+1; rsp_valid_o=1, rsp_id_o=0, rsp_data_o=8 at t+3; issue_cnt_o=retire_cnt_o=1; idle_o=1 at t+4.
- Overflow: A=200, B=100 -> rsp_data_o=44; A=255, B=1 -> 0.
- All four valid continuously for 8 cycles, requester i sending A=i, B=10 -> grants 0,1,2,3,0,1,2,3; responses ids in same order with data 10,11,12,13 repeated, back-to-back pulses.
- Requesters 1 and 3 valid, ptr after reset -> grant 1 then 3 then 1; requester 0 raising valid after grant to 3 wins next.
- pause_i high for 5 cycles during full load -> req_ready_o=0 the same cycle; exactly the issued ops (issue minus retire) still retire; idle_o rises after ADD_LATENCY+2 cycles; resume restarts rotation from saved ptr.
- reset_i pulsed one cycle after two issues -> no rsp_valid_o thereafter, counters 0, add_a_o=add_b_o=0, ptr back to 3.
